// File: rtl/txc_pkg.sv
// Shared types and defaults for the I2C master transmit controller.
package txc_pkg;

  localparam int unsigned TXC_CNT_W         = 6;
  localparam int unsigned TXC_BITS_PER_BYTE = 8;
  localparam int unsigned TXC_BURST_LEN     = 4;
  localparam int unsigned TXC_ACK_TIMEOUT   = 32;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_WRBIT,
    S_ACK_A,
    S_DATA0,
    S_ACK0,
    S_DATA1,
    S_ACK1,
    S_STOP
  } txc_state_t;

  // States in which SCL toggles and every bit occupies two clocks.
  function automatic logic is_bit_state(input txc_state_t s);
    return (s inside {S_ADDR, S_WRBIT, S_ACK_A, S_DATA0, S_ACK0, S_DATA1, S_ACK1});
  endfunction

  function automatic logic is_ack_state(input txc_state_t s);
    return (s inside {S_ACK_A, S_ACK0, S_ACK1});
  endfunction

endpackage

// File: rtl/txc_bitclk.sv
// Bit phase generator: ph alternates 0/1 while run is high, held at 0
// otherwise. bit_end marks the second half of a bit (SCL high).
module txc_bitclk (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic ph,
  output logic bit_end
);

  // Phase toggle; any non-bit cycle restarts the next bit at ph=0.
  always_ff @(posedge clk) begin
    if (reset)    ph <= 1'b0;
    else if (run) ph <= ~ph;
    else          ph <= 1'b0;
  end

  // End-of-bit strobe.
  always_comb begin
    bit_end = run & ph;
  end

endmodule

// File: rtl/tx_controller.sv
// Control FSM of a double-buffered I2C master transmitter.
// Optional feature macro: TXC_ACK_TIMEOUT_EN (ACK wait timeout -> STOP).
module tx_controller
  import txc_pkg::*;
#(
  parameter int unsigned BITS_PER_BYTE = TXC_BITS_PER_BYTE,
  parameter int unsigned BURST_LEN     = TXC_BURST_LEN,
  parameter int unsigned ACK_TIMEOUT   = TXC_ACK_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 StartTX,
  input  logic                 Ackrecvd,
  input  logic [TXC_CNT_W-1:0] TXCount,
  input  logic [TXC_CNT_W-1:0] BurstCnt,
  output logic                 ResetTXCount,
  output logic                 IncTXCount,
  output logic                 ResetBurstCnt,
  output logic                 IncBurstCnt,
  output logic                 LoadAddr,
  output logic                 LoadTXBuf0,
  output logic                 LoadTXBuf1,
  output logic                 ShiftTXBuf0,
  output logic                 ShiftTXBuf1,
  output logic                 PassTXBuf,
  output logic                 SendStartSig,
  output logic                 SendStopSig,
  output logic                 SendWriteSig,
  output logic                 WaitAck,
  output logic                 SDA,
  output logic                 SCL
);

  localparam logic [TXC_CNT_W-1:0] ADDR_LAST  = TXC_CNT_W'(BITS_PER_BYTE - 2);
  localparam logic [TXC_CNT_W-1:0] DATA_LAST  = TXC_CNT_W'(BITS_PER_BYTE - 1);
  localparam logic [TXC_CNT_W-1:0] BURST_LAST = TXC_CNT_W'(BURST_LEN);

  if (BURST_LEN < 1 || BURST_LEN > 63) begin : g_bad_burst
    $error("tx_controller: BURST_LEN must be 1..63");
  end
  if (BITS_PER_BYTE < 2 || BITS_PER_BYTE > 63) begin : g_bad_bits
    $error("tx_controller: BITS_PER_BYTE must be 2..63");
  end
  if (ACK_TIMEOUT < 1) begin : g_bad_timeout
    $error("tx_controller: ACK_TIMEOUT must be at least 1");
  end

  txc_state_t state;
  logic       ph;
  logic       bit_end;
  logic       run;
  logic       in_ack;
  logic       ack_taken;
  logic       timeout;

  // ACK slot qualifiers shared by the FSM and the optional timeout counter.
  always_comb begin
    in_ack    = is_ack_state(state);
    ack_taken = in_ack & ph & Ackrecvd;
  end

`ifdef TXC_ACK_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(ACK_TIMEOUT + 1);

  logic [TO_W-1:0] to_cnt;

  // Counts clocks spent in the current ACK state; cleared on any exit.
  always_ff @(posedge clk) begin
    if (reset || !in_ack || ack_taken || timeout) to_cnt <= '0;
    else                                          to_cnt <= to_cnt + TO_W'(1);
  end

  // Abort when the last permitted ACK clock passes without acceptance.
  always_comb begin
    timeout = in_ack & ~ack_taken & (to_cnt == TO_W'(ACK_TIMEOUT - 1));
  end
`else
  // ACK states wait indefinitely.
  always_comb begin
    timeout = 1'b0;
  end
`endif

  // Phase runs in bit states; a timeout abort forces STOP to start at ph=0.
  always_comb begin
    run = is_bit_state(state) & ~timeout;
  end

  txc_bitclk u_bitclk (
    .clk     (clk),
    .reset   (reset),
    .run     (run),
    .ph      (ph),
    .bit_end (bit_end)
  );

  // Transaction sequencing; all bit-state transitions happen at bit_end.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:  if (StartTX) state <= S_START;
        S_START: state <= S_ADDR;
        S_ADDR:  if (bit_end && TXCount == ADDR_LAST) state <= S_WRBIT;
        S_WRBIT: if (bit_end) state <= S_ACK_A;
        S_ACK_A: begin
          if (ack_taken)    state <= S_DATA0;
          else if (timeout) state <= S_STOP;
        end
        S_DATA0: if (bit_end && TXCount == DATA_LAST) state <= S_ACK0;
        S_ACK0: begin
          if (ack_taken)    state <= (BurstCnt == BURST_LAST) ? S_STOP : S_DATA1;
          else if (timeout) state <= S_STOP;
        end
        S_DATA1: if (bit_end && TXCount == DATA_LAST) state <= S_ACK1;
        S_ACK1: begin
          if (ack_taken)    state <= (BurstCnt == BURST_LAST) ? S_STOP : S_DATA0;
          else if (timeout) state <= S_STOP;
        end
        S_STOP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output decode from state, bit phase and the external bit counter.
  always_comb begin
    ResetTXCount  = 1'b0;
    IncTXCount    = 1'b0;
    ResetBurstCnt = 1'b0;
    IncBurstCnt   = 1'b0;
    LoadAddr      = 1'b0;
    LoadTXBuf0    = 1'b0;
    LoadTXBuf1    = 1'b0;
    ShiftTXBuf0   = 1'b0;
    ShiftTXBuf1   = 1'b0;
    PassTXBuf     = 1'b0;
    SendStartSig  = 1'b0;
    SendStopSig   = 1'b0;
    SendWriteSig  = 1'b0;
    WaitAck       = 1'b0;
    SDA           = 1'b1;
    SCL           = 1'b1;
    unique case (state)
      S_IDLE: begin
        ResetTXCount  = 1'b1;
        ResetBurstCnt = 1'b1;
      end
      S_START: begin
        SendStartSig = 1'b1;
        LoadAddr     = 1'b1;
        SDA          = 1'b0;
      end
      S_ADDR: begin
        SCL         = ph;
        ShiftTXBuf0 = ph;
        IncTXCount  = ph;
      end
      S_WRBIT: begin
        SCL          = ph;
        SendWriteSig = 1'b1;
        SDA          = 1'b0;
      end
      S_ACK_A, S_ACK0, S_ACK1: begin
        SCL          = ph;
        WaitAck      = 1'b1;
        ResetTXCount = 1'b1;
        LoadTXBuf0   = (state == S_ACK_A) & ~ph;
      end
      S_DATA0: begin
        SCL         = ph;
        LoadTXBuf1  = ~ph & (TXCount == '0);
        ShiftTXBuf0 = ph;
        IncTXCount  = ph;
        IncBurstCnt = ph & (TXCount == DATA_LAST);
      end
      S_DATA1: begin
        SCL         = ph;
        PassTXBuf   = 1'b1;
        LoadTXBuf0  = ~ph & (TXCount == '0);
        ShiftTXBuf1 = ph;
        IncTXCount  = ph;
        IncBurstCnt = ph & (TXCount == DATA_LAST);
      end
      S_STOP: begin
        SendStopSig = 1'b1;
        SDA         = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tx_controller.sv
// Self-checking bench for tx_controller: expected cycle-by-cycle output
// traces are expanded from the transaction description (START, address
// bits, write bit, ACK slots with random waits, ping-pong data bytes, STOP).
module tb_tx_controller;

  localparam int unsigned BPB = 8;
  localparam int unsigned BL  = 4;
  localparam int unsigned ATO = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       StartTX;
  logic       Ackrecvd;
  logic [5:0] TXCount  = '0;
  logic [5:0] BurstCnt = '0;
  logic ResetTXCount, IncTXCount, ResetBurstCnt, IncBurstCnt, LoadAddr;
  logic LoadTXBuf0, LoadTXBuf1, ShiftTXBuf0, ShiftTXBuf1, PassTXBuf;
  logic SendStartSig, SendStopSig, SendWriteSig, WaitAck, SDA, SCL;

  tx_controller #(
    .BITS_PER_BYTE (BPB),
    .BURST_LEN     (BL),
    .ACK_TIMEOUT   (ATO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .StartTX       (StartTX),
    .Ackrecvd      (Ackrecvd),
    .TXCount       (TXCount),
    .BurstCnt      (BurstCnt),
    .ResetTXCount  (ResetTXCount),
    .IncTXCount    (IncTXCount),
    .ResetBurstCnt (ResetBurstCnt),
    .IncBurstCnt   (IncBurstCnt),
    .LoadAddr      (LoadAddr),
    .LoadTXBuf0    (LoadTXBuf0),
    .LoadTXBuf1    (LoadTXBuf1),
    .ShiftTXBuf0   (ShiftTXBuf0),
    .ShiftTXBuf1   (ShiftTXBuf1),
    .PassTXBuf     (PassTXBuf),
    .SendStartSig  (SendStartSig),
    .SendStopSig   (SendStopSig),
    .SendWriteSig  (SendWriteSig),
    .WaitAck       (WaitAck),
    .SDA           (SDA),
    .SCL           (SCL)
  );

  always #5 clk = ~clk;

  // External datapath counters driven by the controller strobes.
  always @(posedge clk) begin
    if (ResetTXCount)    TXCount <= '0;
    else if (IncTXCount) TXCount <= TXCount + 6'd1;
    if (ResetBurstCnt)    BurstCnt <= '0;
    else if (IncBurstCnt) BurstCnt <= BurstCnt + 6'd1;
  end

  typedef struct packed {
    logic rtc, itc, rbc, ibc, la, l0, l1, s0, s1, pass, sss, ssp, sws, wa, sda, scl;
  } ov_t;

  typedef struct {
    ov_t   v;
    logic  ack;
    logic  start;
    string tag;
  } step_t;

  step_t       q[$];
  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  ov_t         act;

  assign act = {ResetTXCount, IncTXCount, ResetBurstCnt, IncBurstCnt, LoadAddr,
                LoadTXBuf0, LoadTXBuf1, ShiftTXBuf0, ShiftTXBuf1, PassTXBuf,
                SendStartSig, SendStopSig, SendWriteSig, WaitAck, SDA, SCL};

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic ov_t ov_idle();
    ov_t v = '0;
    v.rtc = 1'b1; v.rbc = 1'b1; v.sda = 1'b1; v.scl = 1'b1;
    return v;
  endfunction

  function automatic ov_t ov_start();
    ov_t v = '0;
    v.sss = 1'b1; v.la = 1'b1; v.scl = 1'b1;
    return v;
  endfunction

  function automatic ov_t ov_addr(input logic ph);
    ov_t v = '0;
    v.sda = 1'b1; v.scl = ph; v.s0 = ph; v.itc = ph;
    return v;
  endfunction

  function automatic ov_t ov_wr(input logic ph);
    ov_t v = '0;
    v.sws = 1'b1; v.scl = ph;
    return v;
  endfunction

  function automatic ov_t ov_ack(input logic first, input logic ph);
    ov_t v = '0;
    v.wa = 1'b1; v.sda = 1'b1; v.rtc = 1'b1; v.scl = ph;
    v.l0 = first & ~ph;
    return v;
  endfunction

  function automatic ov_t ov_data(input logic b, input int unsigned i, input logic ph);
    ov_t v = '0;
    v.pass = b; v.sda = 1'b1; v.scl = ph;
    if (!ph && i == 0) begin
      if (b) v.l0 = 1'b1;
      else   v.l1 = 1'b1;
    end
    if (ph) begin
      if (b) v.s1 = 1'b1;
      else   v.s0 = 1'b1;
      v.itc = 1'b1;
      v.ibc = (i == BPB - 1);
    end
    return v;
  endfunction

  function automatic ov_t ov_stop();
    ov_t v = '0;
    v.ssp = 1'b1; v.scl = 1'b1;
    return v;
  endfunction

  function automatic void push(input ov_t v, input logic ack, input logic st, input string tag);
    step_t s;
    s.v = v; s.ack = ack; s.start = st; s.tag = tag;
    q.push_back(s);
  endfunction

  // ACK wait: 'nacks' refused slots (ack random at ph=0, low at ph=1), then one accepted slot.
  function automatic void add_ack(input logic first, input int unsigned nacks, input string tag);
    for (int unsigned k = 0; k < nacks; k++) begin
      push(ov_ack(first, 1'b0), rbit(), rbit(), tag);
      push(ov_ack(first, 1'b1), 1'b0,   rbit(), tag);
    end
    push(ov_ack(first, 1'b0), rbit(), rbit(), tag);
    push(ov_ack(first, 1'b1), 1'b1,   rbit(), tag);
  endfunction

  function automatic void add_header();
    push(ov_idle(), 1'b0, 1'b1, "idle_start");
    push(ov_start(), rbit(), rbit(), "start");
    for (int unsigned i = 0; i < BPB - 1; i++) begin
      push(ov_addr(1'b0), rbit(), rbit(), "addr");
      push(ov_addr(1'b1), rbit(), rbit(), "addr");
    end
    push(ov_wr(1'b0), rbit(), rbit(), "wrbit");
    push(ov_wr(1'b1), rbit(), rbit(), "wrbit");
  endfunction

  // Full write transaction; long_wait holds the first data ACK low for 20 clk.
  function automatic void build_txn(input logic long_wait);
    add_header();
    add_ack(1'b1, $urandom_range(0, 3), "ack_a");
    for (int unsigned n = 0; n < BL; n++) begin
      logic b = 1'(n % 2);
      for (int unsigned i = 0; i < BPB; i++) begin
        push(ov_data(b, i, 1'b0), rbit(), rbit(), b ? "data1" : "data0");
        push(ov_data(b, i, 1'b1), rbit(), rbit(), b ? "data1" : "data0");
      end
      add_ack(1'b0, (n == 0 && long_wait) ? 10 : $urandom_range(0, 3), b ? "ack1" : "ack0");
    end
    push(ov_stop(), 1'b0, rbit(), "stop");
    push(ov_idle(), 1'b0, 1'b0, "idle_after");
  endfunction

  task automatic check(input ov_t e, input string tag);
    vectors++;
    assert (act === e) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, act, e);
    end
  endtask

  task automatic play_step();
    step_t s = q.pop_front();
    Ackrecvd = s.ack;
    StartTX  = s.start;
    check(s.v, s.tag);
    @(posedge clk); #1;
  endtask

  task automatic play_all();
    while (q.size() > 0) play_step();
  endtask

  // Play until m steps carrying 'tag' have been applied.
  task automatic play_until(input string tag, input int unsigned m);
    int unsigned seen = 0;
    while (q.size() > 0 && seen < m) begin
      if (q[0].tag == tag) seen++;
      play_step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    StartTX  = 1'b1;
    Ackrecvd = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      check(ov_idle(), "reset");
    end
    reset   = 1'b0;
    StartTX = 1'b0;
    @(posedge clk); #1;
    check(ov_idle(), "idle_hold");

    build_txn(1'b1);
    play_all();
    repeat (5) begin
      build_txn(1'b0);
      play_all();
    end

    build_txn(1'b0);
    play_until("data0", 5);
    q.delete();
    reset    = 1'b1;
    StartTX  = 1'b1;
    Ackrecvd = 1'b0;
    @(posedge clk); #1;
    check(ov_idle(), "reset_mid");
    reset   = 1'b0;
    StartTX = 1'b0;
    @(posedge clk); #1;
    check(ov_idle(), "after_reset");
    build_txn(1'b0);
    play_all();

`ifdef TXC_ACK_TIMEOUT_EN
    add_header();
    for (int unsigned c = 0; c < ATO; c++)
      push(ov_ack(1'b1, 1'(c % 2)), 1'b0, rbit(), "ack_timeout");
    push(ov_stop(), 1'b0, rbit(), "timeout_stop");
    push(ov_idle(), 1'b0, 1'b0, "timeout_idle");
    play_all();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
